// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter, one frame per valid/ready handshake, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 uartTxPin,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS) + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic [BW-1:0]        baud;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 line;
    logic                 line_next;
    logic                 bit_end;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign bit_end   = (baud == BW'(CLKS_PER_BIT - 1));
    assign accept    = valid && (state == IDLE);
    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign uartTxPin = line;

    always_comb begin
        state_next = state;
        line_next  = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                line_next = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                line_next = shift[0];
                if (bit_end && idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_next = par;
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                // done fires in the last stop cycle so ready rises right after it
                done = bit_end;
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
            line  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            line  <= line_next;
            if (state == IDLE || bit_end) baud <= '0;
            else                          baud <= baud + BW'(1);
            if (state == START)                idx <= '0;
            else if (state == DATA && bit_end) idx <= idx + IW'(1);
            if (accept)                        shift <= data;
            else if (state == DATA && bit_end) shift <= shift >> 1;
`ifdef UART_TX_PARITY_EN
            if (accept) par <= ^data;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames at CLKS_PER_BIT=4, decoded by a line sampler.
// Parity frame checks apply when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       uartTxPin;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc1;
    int acc2;
    int last_acc;
    int dcount;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .uartTxPin (uartTxPin),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sends b, then decodes the line and checks framing and done timing.
    task automatic tx_frame(input logic [7:0] b, input logic [7:0] nxt,
                            input logic keep, input logic glitch,
                            input string tag);
        logic       s [0:63];
        logic [7:0] got;
        int         dcyc;
        int         dn;
        bit         ok;
        data  = b;
        valid = 1'b1;
        ok    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check({tag, "_accept_timeout"}, 0, 1);
            valid = 1'b0;
            return;
        end
        @(posedge clock);
        last_acc = cyc;
        dcyc = 0;
        dn   = 0;
        for (int n = 1; n <= FRAME; n++) begin
            @(negedge clock);
            if (n == 1) begin
                data  = nxt;
                valid = keep;
            end
            if (glitch && n == 20) begin
                data  = 8'hFF;
                valid = 1'b1;
            end
            if (glitch && n == 21) valid = 1'b0;
            s[n] = uartTxPin;
            if (done) begin
                dn++;
                if (dcyc == 0) dcyc = n;
            end
            if (n == 20) check({tag, "_busy_mid"}, int'(busy), 1);
            if (n == FRAME) check({tag, "_ready_at_done"}, int'(ready), 0);
        end
        for (int i = 0; i < 8; i++) got[i] = s[4 * (i + 1) + 3];
        check({tag, "_start"}, int'(s[3]), 0);
        check({tag, "_data"}, int'(got), int'(b));
`ifdef UART_TX_PARITY_EN
        check({tag, "_parity"}, int'(s[4 * 9 + 3]), int'(^b));
`endif
        check({tag, "_stop"}, int'(s[4 * (NBITS - 1) + 3]), 1);
        check({tag, "_done_cycle"}, dcyc, FRAME);
        check({tag, "_done_count"}, dn, 1);
    endtask

    initial begin
        reset = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        // reset held three cycles with valid low
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_line", int'(uartTxPin), 1);
            check("rst_ready", int'(ready), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
        end
        // reset wins over a simultaneous valid
        valid = 1'b1;
        data  = 8'hAA;
        @(negedge clock);
        check("rst_valid_busy", int'(busy), 0);
        check("rst_valid_line", int'(uartTxPin), 1);
        valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        tx_frame(8'h55, 8'h00, 1'b0, 1'b0, "f55");
        @(negedge clock);
        check("f55_ready_after", int'(ready), 1);

        // back-to-back: valid stays high across the first frame
        tx_frame(8'hA3, 8'h0F, 1'b1, 1'b0, "fA3");
        acc1 = last_acc;
        tx_frame(8'h0F, 8'h00, 1'b0, 1'b0, "f0F");
        acc2 = last_acc;
        check("b2b_gap", acc2 - acc1, FRAME + 1);

        // 0xFF pulsed mid-frame must be dropped
        tx_frame(8'h00, 8'h00, 1'b0, 1'b1, "f00");
        repeat (2 * FRAME) begin
            @(negedge clock);
            if (busy || !uartTxPin) break;
        end
        check("glitch_busy", int'(busy), 0);
        check("glitch_line", int'(uartTxPin), 1);

        // reset during data bit 3 of 0x00
        data  = 8'h00;
        valid = 1'b1;
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        valid = 1'b0;
        repeat (17) @(negedge clock);
        check("mid_line_low", int'(uartTxPin), 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_line", int'(uartTxPin), 1);
        check("mid_rst_ready", int'(ready), 1);
        check("mid_rst_busy", int'(busy), 0);
        dcount = 0;
        repeat (FRAME) begin
            @(negedge clock);
            if (done || !uartTxPin) dcount++;
        end
        check("mid_rst_quiet", dcount, 0);
        tx_frame(8'h3C, 8'h00, 1'b0, 1'b0, "f3C");

`ifdef UART_TX_PARITY_EN
        tx_frame(8'h07, 8'h00, 1'b0, 1'b0, "p07");
        tx_frame(8'h03, 8'h00, 1'b0, 1'b0, "p03");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
